// File: rtl/slave_master_mode_ctrl.sv
// Timer trigger selection, slave-mode control (reset/gated/trigger/ext-clock) and master-mode TRGO.
// Optional macro MSM_DELAY_EN adds one register stage on the slave trigger path; TRGO timing is unaffected.
module slave_master_mode_ctrl #(
  parameter int ITR_NUM      = 4,
  parameter int CH_NUM       = 4,
  parameter int SYNC_STAGES  = 2,
  localparam int TS_W        = $clog2(ITR_NUM + 4)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ITR_NUM-1:0] itr_i,
  input  logic              ti1_ed_i,
  input  logic              ti1fp1_i,
  input  logic              ti2fp2_i,
  input  logic              etrf_i,
  input  logic [TS_W-1:0]   ts_i,
  input  logic [2:0]        sms_i,
  input  logic [2:0]        mms_i,
  input  logic              cen_i,
  input  logic              ug_i,
  input  logic              uev_i,
  input  logic              enc_tick_i,
  input  logic [CH_NUM-1:0] ccif_i,
  input  logic [CH_NUM-1:0] ocref_i,
  output logic              cnt_tick_o,
  output logic              sm_reset_o,
  output logic              cen_set_o,
  output logic              tif_o,
  output logic              trgo_o
);

  localparam int SRC_N = 1 << TS_W;

  localparam logic [2:0] SMS_INT   = 3'b000;
  localparam logic [2:0] SMS_ENC1  = 3'b001;
  localparam logic [2:0] SMS_ENC2  = 3'b010;
  localparam logic [2:0] SMS_ENC3  = 3'b011;
  localparam logic [2:0] SMS_RESET = 3'b100;
  localparam logic [2:0] SMS_GATED = 3'b101;
  localparam logic [2:0] SMS_TRIG  = 3'b110;
  localparam logic [2:0] SMS_EXT1  = 3'b111;

  localparam logic [2:0] MMS_RESET  = 3'b000;
  localparam logic [2:0] MMS_ENABLE = 3'b001;
  localparam logic [2:0] MMS_UPDATE = 3'b010;
  localparam logic [2:0] MMS_CMPPLS = 3'b011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic [ITR_NUM-1:0] sync_q [SYNC_STAGES];
  logic [ITR_NUM-1:0] itr_sync_s;
  logic [SRC_N-1:0]   src_s;
  logic               trgi_s;
  logic               trgi_q;
  logic [TS_W-1:0]    ts_q;
  logic               ts_chg_s;
  logic               rise_s;
  logic               fall_s;
  logic [2:0]         sms_q;
  logic               sms_chg_s;

  logic               slv_rise_s;
  logic               slv_fall_s;
  logic               slv_lvl_s;

  state_e             state_q;
  state_e             state_d;
  logic               cnt_tick_q;
  logic               cnt_tick_d;
  logic               sm_reset_q;
  logic               sm_reset_d;
  logic               cen_set_q;
  logic               cen_set_d;
  logic               tif_q;
  logic               tif_d;

  logic               rst_evt_q;
  logic               rst_evt_d;
  logic               ug_q;
  logic               trgo_q;
  logic               trgo_d;
  logic [3:0]         oc_ext_s;
  logic               ccif_unused_s;

  assign ccif_unused_s = ^ccif_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {ITR_NUM{1'b0}};
      end
    end else begin
      sync_q[0] <= itr_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign itr_sync_s = sync_q[SYNC_STAGES-1];

  // Flatten every trigger source into one vector so ts_i indexes it directly; unused codes read 0.
  always_comb begin
    src_s              = {SRC_N{1'b0}};
    src_s[ITR_NUM-1:0] = itr_sync_s;
    src_s[ITR_NUM]     = ti1_ed_i;
    src_s[ITR_NUM+1]   = ti1fp1_i;
    src_s[ITR_NUM+2]   = ti2fp2_i;
    src_s[ITR_NUM+3]   = etrf_i;
  end

  assign trgi_s    = src_s[ts_i];
  assign ts_chg_s  = (ts_i != ts_q);
  assign sms_chg_s = (sms_i != sms_q);
  assign rise_s    = trgi_s & ~trgi_q & ~ts_chg_s;
  assign fall_s    = ~trgi_s & trgi_q & ~ts_chg_s;

`ifdef MSM_DELAY_EN
  logic rise_dly_q;
  logic fall_dly_q;
  logic lvl_dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_dly_q <= 1'b0;
      fall_dly_q <= 1'b0;
      lvl_dly_q  <= 1'b0;
    end else begin
      rise_dly_q <= rise_s & ~sms_chg_s;
      fall_dly_q <= fall_s & ~sms_chg_s;
      lvl_dly_q  <= trgi_q;
    end
  end

  assign slv_rise_s = rise_dly_q;
  assign slv_fall_s = fall_dly_q;
  assign slv_lvl_s  = lvl_dly_q;
`else
  assign slv_rise_s = rise_s;
  assign slv_fall_s = fall_s;
  assign slv_lvl_s  = trgi_q;
`endif

  // A slave-mode change forces IDLE and swallows every slave output for that cycle.
  always_comb begin
    state_d    = ST_IDLE;
    cnt_tick_d = 1'b0;
    sm_reset_d = 1'b0;
    cen_set_d  = 1'b0;
    tif_d      = 1'b0;
    if (sms_chg_s) begin
      state_d = ST_IDLE;
    end else begin
      case (sms_i)
        SMS_INT: begin
          cnt_tick_d = cen_i;
        end
        SMS_ENC1, SMS_ENC2, SMS_ENC3: begin
          cnt_tick_d = cen_i & enc_tick_i;
        end
        SMS_RESET: begin
          cnt_tick_d = cen_i;
          sm_reset_d = slv_rise_s;
          tif_d      = slv_rise_s;
        end
        SMS_GATED: begin
          cnt_tick_d = cen_i & slv_lvl_s;
          tif_d      = slv_rise_s | slv_fall_s;
        end
        SMS_TRIG: begin
          cnt_tick_d = cen_i;
          tif_d      = slv_rise_s;
          case (state_q)
            ST_IDLE: begin
              if (slv_rise_s) begin
                state_d   = ST_RUN;
                cen_set_d = 1'b1;
              end else begin
                state_d   = ST_IDLE;
              end
            end
            ST_RUN: begin
              if (cen_i) begin
                state_d = ST_RUN;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
        SMS_EXT1: begin
          cnt_tick_d = cen_i & slv_rise_s;
          tif_d      = slv_rise_s;
        end
        default: begin
          cnt_tick_d = 1'b0;
        end
      endcase
    end
  end

  // TRGO reset source is the undelayed slave reset so coupled timers see it with fixed latency.
  assign rst_evt_d = (sms_i == SMS_RESET) & rise_s & ~sms_chg_s;

  always_comb begin
    oc_ext_s               = 4'b0000;
    oc_ext_s[CH_NUM-1:0]   = ocref_i;
  end

  // A slave reset that follows a ug_i in the previous cycle is merged into the ug_i pulse.
  always_comb begin
    trgo_d = 1'b0;
    case (mms_i)
      MMS_RESET: begin
        trgo_d = ug_i | (rst_evt_q & ~ug_q);
      end
      MMS_ENABLE: begin
        if (sms_i == SMS_GATED) begin
          trgo_d = cen_i & trgi_q;
        end else begin
          trgo_d = cen_i;
        end
      end
      MMS_UPDATE: begin
        trgo_d = uev_i;
      end
      MMS_CMPPLS: begin
        trgo_d = ccif_i[0];
      end
      default: begin
        trgo_d = oc_ext_s[mms_i[1:0]];
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      trgi_q     <= 1'b0;
      ts_q       <= {TS_W{1'b0}};
      sms_q      <= 3'b000;
      cnt_tick_q <= 1'b0;
      sm_reset_q <= 1'b0;
      cen_set_q  <= 1'b0;
      tif_q      <= 1'b0;
      rst_evt_q  <= 1'b0;
      ug_q       <= 1'b0;
      trgo_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trgi_q     <= trgi_s;
      ts_q       <= ts_i;
      sms_q      <= sms_i;
      cnt_tick_q <= cnt_tick_d;
      sm_reset_q <= sm_reset_d;
      cen_set_q  <= cen_set_d;
      tif_q      <= tif_d;
      rst_evt_q  <= rst_evt_d;
      ug_q       <= ug_i;
      trgo_q     <= trgo_d;
    end
  end

  assign cnt_tick_o = cnt_tick_q;
  assign sm_reset_o = sm_reset_q;
  assign cen_set_o  = cen_set_q;
  assign tif_o      = tif_q;
  assign trgo_o     = trgo_q;

endmodule

// File: tb/tb_slave_master_mode_ctrl.sv
// Scoreboard bench for slave_master_mode_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_slave_master_mode_ctrl;

  localparam int ITR_NUM     = 4;
  localparam int CH_NUM      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TS_W        = $clog2(ITR_NUM + 4);
`ifdef MSM_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  localparam logic [TS_W-1:0] TS_ITR1 = TS_W'(1);
  localparam logic [TS_W-1:0] TS_TI2  = TS_W'(ITR_NUM + 2);
  localparam logic [TS_W-1:0] TS_ETR  = TS_W'(ITR_NUM + 3);

  // bit order: {trgo2, cnt_tick, sm_reset, cen_set, tif, trgo}
  localparam logic [5:0] M_ALL  = 6'b111111;
  localparam logic [5:0] M_MAIN = 6'b011111;
  localparam logic [5:0] M_SLV  = 6'b011110;
  localparam logic [5:0] M_T2   = 6'b100001;

  logic               clk = 1'b0;
  logic               rst_i;
  logic [ITR_NUM-1:0] itr_i;
  logic               ti1_ed_i, ti1fp1_i, ti2fp2_i, etrf_i;
  logic [TS_W-1:0]    ts_i;
  logic [2:0]         sms_i, mms_i;
  logic               cen_i, ug_i, uev_i, enc_tick_i;
  logic [CH_NUM-1:0]  ccif_i, ocref_i;
  logic               cnt_tick_o, sm_reset_o, cen_set_o, tif_o, trgo_o;
  logic               cnt2, smr2, cens2, tif2, trgo2;

  slave_master_mode_ctrl #(.ITR_NUM(ITR_NUM), .CH_NUM(CH_NUM), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i(clk), .rst_i(rst_i), .itr_i(itr_i), .ti1_ed_i(ti1_ed_i), .ti1fp1_i(ti1fp1_i),
    .ti2fp2_i(ti2fp2_i), .etrf_i(etrf_i), .ts_i(ts_i), .sms_i(sms_i), .mms_i(mms_i),
    .cen_i(cen_i), .ug_i(ug_i), .uev_i(uev_i), .enc_tick_i(enc_tick_i), .ccif_i(ccif_i),
    .ocref_i(ocref_i), .cnt_tick_o(cnt_tick_o), .sm_reset_o(sm_reset_o), .cen_set_o(cen_set_o),
    .tif_o(tif_o), .trgo_o(trgo_o)
  );

  slave_master_mode_ctrl #(.ITR_NUM(ITR_NUM), .CH_NUM(2), .SYNC_STAGES(SYNC_STAGES)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .itr_i(itr_i), .ti1_ed_i(ti1_ed_i), .ti1fp1_i(ti1fp1_i),
    .ti2fp2_i(ti2fp2_i), .etrf_i(etrf_i), .ts_i(ts_i), .sms_i(sms_i), .mms_i(mms_i),
    .cen_i(cen_i), .ug_i(ug_i), .uev_i(uev_i), .enc_tick_i(enc_tick_i), .ccif_i(ccif_i[1:0]),
    .ocref_i(ocref_i[1:0]), .cnt_tick_o(cnt2), .sm_reset_o(smr2), .cen_set_o(cens2),
    .tif_o(tif2), .trgo_o(trgo2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] val;
    logic [5:0] msk;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [5:0] mk(input logic cnt, input logic smr, input logic cens,
                                    input logic tif, input logic trgo, input logic t2);
    return {t2, cnt, smr, cens, tif, trgo};
  endfunction

  task automatic exp_at(input int c, input logic [5:0] v, input logic [5:0] m, input string nm);
    exp_t e;
    e.cyc = c;
    e.val = v;
    e.msk = m;
    e.nm  = nm;
    sb_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] obs;
    obs = {trgo2, cnt_tick_o, sm_reset_o, cen_set_o, tif_o, trgo_o};
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_chk++;
      if (e.cyc != cyc || ((obs ^ e.val) & e.msk) != 6'b000000) begin
        $display("FAIL %s cyc=%0d (due %0d) got=%b want=%b mask=%b", e.nm, cyc, e.cyc, obs, e.val, e.msk);
      end else begin
        n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    rst_i = 1'b1; itr_i = '0; ti1_ed_i = 1'b0; ti1fp1_i = 1'b0; ti2fp2_i = 1'b0; etrf_i = 1'b0;
    ts_i = '0; sms_i = 3'b000; mms_i = 3'b001; cen_i = 1'b1; ug_i = 1'b0; uev_i = 1'b0;
    enc_tick_i = 1'b0; ccif_i = '0; ocref_i = '0;

    // reset held 3 cycles, then internal clock and enable-mode TRGO
    for (int c = 1; c <= 3; c++) exp_at(c, 6'b000000, M_ALL, "reset_outputs");
    exp_at(4, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), M_ALL, "post_reset");
    goto(3);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // reset mode via synchronised itr_i[1]
    sms_i = 3'b100; mms_i = 3'b000; ts_i = TS_ITR1;
    repeat (4) @(negedge clk);
    b = cyc;
    for (int c = b + 1; c <= b + 6; c++)
      exp_at(c, mk(1'b1, c == b + SYNC_STAGES + 1 + DLY, 1'b0, c == b + SYNC_STAGES + 1 + DLY,
                   c == b + SYNC_STAGES + 2, 1'b0), M_MAIN, "itr_reset_mode");
    itr_i[1] = 1'b1;
    goto(b + 8);

    // ug_i coincident with a rise: one TRGO pulse
    itr_i = '0; ts_i = TS_ETR;
    repeat (4) @(negedge clk);
    b = cyc;
    for (int c = b + 1; c <= b + 4; c++)
      exp_at(c, mk(1'b1, c == b + 1 + DLY, 1'b0, c == b + 1 + DLY, c == b + 1, 1'b0), M_MAIN, "ug_merge");
    etrf_i = 1'b1; ug_i = 1'b1;
    goto(b + 1);
    ug_i = 1'b0;
    goto(b + 6);

    // trigger mode FSM
    sms_i = 3'b110; mms_i = 3'b001; cen_i = 1'b0; etrf_i = 1'b0;
    repeat (4) @(negedge clk);
    b = cyc;
    for (int c = b + 1; c <= b + 3; c++)
      exp_at(c, mk(c >= b + 2 + DLY, 1'b0, c == b + 1 + DLY, c == b + 1 + DLY, c >= b + 2 + DLY, 1'b0),
             M_MAIN, "trig_first");
    for (int c = b + 5; c <= b + 9; c++)
      exp_at(c, mk(1'b1, 1'b0, 1'b0, c == b + 7 + DLY, 1'b1, 1'b0), M_MAIN, "trig_run_rise");
    for (int c = b + 11; c <= b + 16; c++)
      exp_at(c, mk(1'b0, 1'b0, c == b + 14 + DLY, c == b + 14 + DLY, 1'b0, 1'b0), M_MAIN, "trig_rearm");
    etrf_i = 1'b1;
    goto(b + 1 + DLY); cen_i = 1'b1;
    goto(b + 4);  etrf_i = 1'b0;
    goto(b + 6);  etrf_i = 1'b1;
    goto(b + 10); etrf_i = 1'b0; cen_i = 1'b0;
    goto(b + 13); etrf_i = 1'b1;
    goto(b + 17);

    // gated mode, trigger high 5 cycles
    sms_i = 3'b101; mms_i = 3'b001; cen_i = 1'b1; etrf_i = 1'b0;
    repeat (4) @(negedge clk);
    b = cyc;
    for (int c = b + 1; c <= b + 8; c++)
      exp_at(c, mk(c >= b + 2 + DLY && c <= b + 6 + DLY, 1'b0, 1'b0,
                   c == b + 1 + DLY || c == b + 6 + DLY, c >= b + 2 && c <= b + 6, 1'b0), M_MAIN, "gated");
    etrf_i = 1'b1;
    goto(b + 5); etrf_i = 1'b0;
    goto(b + 10);

    // external clock mode 1, etrf toggling every 3 cycles
    sms_i = 3'b111;
    repeat (4) @(negedge clk);
    b = cyc;
    for (int c = b + 1; c <= b + 13; c++)
      exp_at(c, mk(c == b + 1 + DLY || c == b + 7 + DLY, 1'b0, 1'b0, c == b + 1 + DLY || c == b + 7 + DLY,
                   1'b0, 1'b0), M_SLV, "ext_clock");
    etrf_i = 1'b1;
    goto(b + 3); etrf_i = 1'b0;
    goto(b + 6); etrf_i = 1'b1;
    goto(b + 9); etrf_i = 1'b0;
    goto(b + 14);
    b = cyc;
    for (int c = b + 1; c <= b + 4; c++)
      exp_at(c, 6'b000000, M_SLV, "ts_change_no_tick");
    ts_i = TS_TI2; ti2fp2_i = 1'b1;
    goto(b + 6);

    // master modes: OCREF select, compare pulse, update
    sms_i = 3'b000; mms_i = 3'b110; ocref_i = 4'b0100;
    b = cyc;
    for (int c = b + 1; c <= b + 2; c++)
      exp_at(c, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), M_T2, "trgo_ocref");
    for (int c = b + 3; c <= b + 7; c++)
      exp_at(c, mk(1'b0, 1'b0, 1'b0, 1'b0, c == b + 5, c == b + 5), M_T2, "trgo_ccif");
    for (int c = b + 9; c <= b + 11; c++)
      exp_at(c, mk(1'b0, 1'b0, 1'b0, 1'b0, c == b + 9, c == b + 9), M_T2, "trgo_update");
    goto(b + 2); mms_i = 3'b011;
    goto(b + 4); ccif_i = 4'b0001;
    goto(b + 5); ccif_i = 4'b0000;
    goto(b + 8); mms_i = 3'b010; uev_i = 1'b1;
    goto(b + 9); uev_i = 1'b0;
    goto(b + 12);

    // reset wins over a coincident rise and ug_i
    sms_i = 3'b100; mms_i = 3'b000; ts_i = TS_ETR; ti2fp2_i = 1'b0; etrf_i = 1'b0; ocref_i = '0;
    repeat (4) @(negedge clk);
    b = cyc;
    exp_at(b + 1, 6'b000000, M_ALL, "reset_priority");
    for (int c = b + 2; c <= b + 4; c++)
      exp_at(c, 6'b000000, 6'b001111, "after_reset_quiet");
    rst_i = 1'b1; etrf_i = 1'b1; ug_i = 1'b1;
    goto(b + 1);
    rst_i = 1'b0; ug_i = 1'b0;
    goto(b + 6);

    repeat (20) begin
      if (sb_q.size() > 0) @(negedge clk);
    end
    if (sb_q.size() > 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain left=%0d", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/slave_master_mode_ctrl.md
Name: slave_master_mode_ctrl

Overview:
- Parametrised successor of the timer trigger/slave-mode block.
- Generalises the internal-trigger count.
- Replaces clock muxing with a clock-enable tick.
- Adds a registered edge-detect trigger path, a trigger-mode state machine and a fully implemented master-mode TRGO generator.
- Sits between the input stage (filtered TI/ETR) and the counter/prescaler. Drives counter tick, slave reset, CEN set and TRGO to other timers.

Parameters:
ITR_NUM, 4, number of internal trigger inputs (1..8)
CH_NUM, 4, number of compare channels feeding TRGO (1..4)
SYNC_STAGES, 2, synchroniser depth on itr_i (>=2)

Ports:
clk_i  in  1  timer kernel clock
rst_i  in  1  synchronous reset, active-high
itr_i  in  ITR_NUM  internal triggers from other timers (asynchronous)
ti1_ed_i  in  1  TI1 edge detector, clk_i domain
ti1fp1_i  in  1  filtered TI1, clk_i domain
ti2fp2_i  in  1  filtered TI2, clk_i domain
etrf_i  in  1  filtered ETR, clk_i domain
ts_i  in  TS_W=$clog2(ITR_NUM+4)  trigger select
sms_i  in  3  slave mode select
mms_i  in  3  master mode select
cen_i  in  1  counter enable bit
ug_i  in  1  software update-generation pulse
uev_i  in  1  counter update event pulse
enc_tick_i  in  1  encoder count pulse
ccif_i  in  CH_NUM  capture/compare flag pulses
ocref_i  in  CH_NUM  output-compare reference levels
cnt_tick_o  out  1  counter clock enable
sm_reset_o  out  1  slave reset pulse
cen_set_o  out  1  request to set CEN
tif_o  out  1  trigger interrupt flag pulse
trgo_o  out  1  trigger output

Behaviour:
- Reset:
  - All outputs 0.
  - Synchroniser flops, trgi_q and ts_q are 0.
  - FSM in IDLE.
  - Reset wins over every other event in the same cycle.
- Trigger select:
  - ts_i 0..ITR_NUM-1 selects the synchronised itr_i[ts_i] (SYNC_STAGES flops).
  - ITR_NUM selects ti1_ed_i; +1 selects ti1fp1_i; +2 selects ti2fp2_i; +3 selects etrf_i.
  - Any other value gives trgi = 0.
- Edge detection:
  - trgi_q is trgi registered every cycle.
  - rise = trgi & ~trgi_q; fall = ~trgi & trgi_q.
  - ts_q registers ts_i. In any cycle where ts_i != ts_q, rise and fall are forced to 0.
- Latency: a post-sync rise in cycle N asserts sm_reset_o, cen_set_o and tif_o in cycle N+1. Every pulse is exactly 1 cycle wide.
- sms_i modes:
  - 000 internal: cnt_tick_o = cen_i.
  - 001/010/011 encoder: cnt_tick_o = cen_i & enc_tick_i.
  - 100 reset: cnt_tick_o = cen_i. On rise: sm_reset_o and tif_o pulse.
  - 101 gated: cnt_tick_o = cen_i & trgi_q. tif_o pulses on rise and on fall.
  - 110 trigger: cnt_tick_o = cen_i. FSM:
    - IDLE to RUN on rise, with a cen_set_o + tif_o pulse.
    - RUN to IDLE when cen_i = 0.
    - Rises while in RUN give tif_o only.
  - 111 external clock 1: cnt_tick_o = cen_i & rise, registered (1-cycle latency). tif_o pulses on each rise.
- sms_i change: the FSM returns to IDLE and no pulse is issued in the cycle of the change.
- TRGO (mms_i), always registered, 1-cycle latency:
  - 000 reset: trgo_o pulses when ug_i or sm_reset_o.
  - 001 enable: trgo_o = cen_i. In gated mode it is cen_i & trgi_q.
  - 010 update: trgo_o pulses when uev_i.
  - 011 compare pulse: trgo_o pulses on ccif_i[0].
  - 1xx (k = mms_i[1:0]): trgo_o = ocref_i[k] for k < CH_NUM, otherwise 0.
- Simultaneous ug_i and rise in reset mode produce a single 1-cycle trgo_o pulse, not two.

Optional Feature:
- Macro: MSM_DELAY_EN (master/slave synchronisation).
- Defined:
  - One extra register stage on rise/fall and on trgi_q before slave actions, so slave latency becomes N+2.
  - The TRGO path is unchanged, so coupled timers start together.
- Undefined: latency is N+1 as specified above.

Test Plan:
- Setup: rst_i held 3 cycles with cen_i=1, sms_i=000, mms_i=001. Expect all outputs 0 during reset. In the first cycle after release, cnt_tick_o=1 and trgo_o=1.
- Setup: sms_i=100, ts_i=1, itr_i[1] 0 to 1 asynchronously. Expect sm_reset_o and tif_o high for exactly 1 cycle, SYNC_STAGES+1 cycles after the itr_i[1] edge; +1 cycle with MSM_DELAY_EN. With mms_i=000, trgo_o pulses 1 cycle later.
- Setup: sms_i=110, cen_i=0, ts_i=ITR_NUM+3, etrf_i rises. Expect cen_set_o pulse; then a second rise gives tif_o only. Clearing cen_i returns the FSM to IDLE, and the next rise gives cen_set_o again.
- Setup: sms_i=101, cen_i=1, trgi high for 5 cycles. Expect exactly 5 cnt_tick_o cycles, plus tif_o pulses at start and end.
- Setup: sms_i=111, etrf_i toggling every 3 cycles for 12 cycles. Expect 2 cnt_tick_o pulses (one per rise). Changing ts_i in the same cycle as a rise produces no tick.
- Setup: mms_i=110, ocref_i=4'b0100, then mms_i=011 with a ccif_i[0] pulse. Expect trgo_o=1 one cycle later, then a single-cycle trgo_o pulse; with CH_NUM=2, mms_i=110 gives trgo_o=0.
